seq_alu: RTL
============

# seq_alu

Parametrised, handshaked successor to the project's single-cycle ALU. It keeps the existing operation codes, adds shifts, signed/unsigned compare and an iterative multiplier and divider, and registers every result behind a valid/ready interface. It sits between the ID/EX pipeline register and the EX/MEM stage. Multi-cycle operations stall issue through `ready_o`.

## Interface
- `WIDTH`, default 32: operand and result width; power of two, at least 8.
- `CNT_W`, default `$clog2(WIDTH)+1`: iteration counter width; derived, do not override.
- `clk_i`  in  1: clock; all logic on the rising edge.
- `rst_i`  in  1: reset; **synchronous, active-high**.
- `valid_i`  in  1: operation request.
- `ready_o`  out  1: block can accept a request this cycle.
- `src1_i`  in  WIDTH: operand A.
- `src2_i`  in  WIDTH: operand B; shift amount is `src2_i[$clog2(WIDTH)-1:0]`.
- `ctrl_i`  in  4: operation code.
- `valid_o`  out  1: `result_o`, `zero_o` and `ovf_o` are valid.
- `ready_i`  in  1: consumer accepts the result.
- `result_o`  out  WIDTH: registered result.
- `zero_o`  out  1: registered, equals `result_o == 0`.
- `ovf_o`  out  1: signed overflow of ADD or SUB; 0 for every other operation.

## Operation
- A request is accepted when `valid_i && ready_o`. Operands and `ctrl_i` are captured at acceptance.
- Operation codes:
  - 0 AND
  - 1 OR
  - 2 ADD
  - 3 SLTU (unsigned)
  - 4 SLL
  - 5 SRL
  - 6 SUB
  - 7 SLT (signed)
  - 8 SRA
  - 10 MUL: low WIDTH bits of the product; operand signedness irrelevant.
  - 12 NOR
  - 13 DIVU quotient
  - 14 REMU remainder
  - Any other code: result 0.
- SLT/SLTU return 1 or 0 in bit 0, zero-extended.
- ADD/SUB wrap modulo 2^WIDTH. `ovf_o` is set when both operands have the same sign (ADD) or different signs (SUB) and the result sign differs from A.
- FSM states:
  - IDLE: accepts requests. Single-cycle codes load the output register directly and stay in IDLE. MUL, DIVU and REMU load the iteration unit and go to BUSY.
  - BUSY: one shift-add (MUL) or restoring-divide (DIVU/REMU) step per cycle for WIDTH cycles. On the last step the output register is loaded and the FSM returns to IDLE.
- `ready_o = (state == IDLE) && (!valid_o || ready_i)`. A new result never overwrites an unconsumed one.
- The output register clears `valid_o` on `valid_o && ready_i` unless it is reloaded in the same cycle.
- Divide by zero: quotient is all-ones, remainder equals A. No exception is raised.

## Timing
- Reset values: `valid_o`=0, `ready_o`=1 (from the following cycle onward), `result_o`=0, `zero_o`=1, `ovf_o`=0, state=IDLE, counter=0.
- Reset takes priority over every other event. Reset during BUSY aborts the operation, and no result is produced.
- Single-cycle operations: accepted at edge N, `valid_o` high after edge N+1 (latency 1). Back-to-back issue sustains 1 operation per cycle while `ready_i`=1.
- MUL/DIVU/REMU: accepted at edge N, `valid_o` high after edge N+WIDTH+1. `ready_o` is low throughout BUSY.
- `valid_o`, `result_o`, `zero_o` and `ovf_o` hold stable while `valid_o && !ready_i`.
- When `valid_o && ready_i` and a new request are accepted in the same cycle, the new result replaces the old one on the next edge and `valid_o` stays high.
- `valid_i` is ignored while `ready_o`=0. Requesters hold their request until it is accepted.

## Configuration
- `SEQ_ALU_DIV_EN` defined: DIVU (13) and REMU (14) are implemented as above.
- `SEQ_ALU_DIV_EN` not defined: the divider datapath is removed. Codes 13 and 14 behave as unsupported codes: single-cycle, result 0, `zero_o`=1. MUL is unaffected.

## Structure
- Package `seq_alu_pkg` holds:
  - the `alu_op_e` enum with all codes above, including the unsupported-code default;
  - the `alu_state_e` enum {IDLE, BUSY};
  - the `ALU_LATENCY_ITER` constant, documented as WIDTH+1.
- Sub-module `seq_alu_iter` holds the shared shift-add multiplier and restoring divider. It has shared accumulator and counter registers, start/done pins, and WIDTH as a parameter. The divider portion is guarded by `SEQ_ALU_DIV_EN`.
- The top level holds the FSM, the combinational single-cycle datapath and the output register.

## Test plan
- Reset mid-MUL: issue MUL 3×5, assert `rst_i` on cycle 10 → `valid_o` stays 0, `ready_o`=1 the cycle after reset is released, outputs at reset values.
- Single-cycle ops, WIDTH=32, `ready_i`=1:
  - ADD 0x7FFFFFFF+1 → 0x80000000, `ovf_o`=1, latency 1.
  - SUB 5-5 → 0, `zero_o`=1.
  - SLT 0xFFFFFFFF vs 1 → 1.
  - SLTU 0xFFFFFFFF vs 1 → 0.
  - SRA 0x80000000 by 4 → 0xF8000000.
- MUL 0xFFFFFFFF×3 → 0xFFFFFFFD after exactly 33 cycles; `ready_o`=0 during BUSY.
- Backpressure: hold `ready_i`=0 after an ADD result, issue a second ADD → `ready_o`=0, first result held unchanged; release `ready_i` → second result appears the next cycle.
- With `SEQ_ALU_DIV_EN`: DIVU 100/7 → 14; REMU 100/7 → 2; DIVU x/0 → 0xFFFFFFFF; REMU 9/0 → 9. Without the macro: code 13 → result 0 after 1 cycle.
- Back-to-back single-cycle stream of 8 ops with `ready_i`=1 → 8 results on 8 consecutive cycles, in order.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential ALU.
// Optional feature macro: SEQ_ALU_DIV_EN (enables the DIVU/REMU iterative divider).
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_AND    = 4'd0,
    OP_OR     = 4'd1,
    OP_ADD    = 4'd2,
    OP_SLTU   = 4'd3,
    OP_SLL    = 4'd4,
    OP_SRL    = 4'd5,
    OP_SUB    = 4'd6,
    OP_SLT    = 4'd7,
    OP_SRA    = 4'd8,
    OP_MUL    = 4'd10,
    OP_NOR    = 4'd12,
    OP_DIVU   = 4'd13,
    OP_REMU   = 4'd14,
    OP_UNSUP  = 4'd15   // representative of every unassigned code: result 0
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_e;

  // Which function the shared iteration unit is running.
  typedef enum logic [1:0] {
    ITER_MUL  = 2'd0,
    ITER_DIVU = 2'd1,
    ITER_REMU = 2'd2
  } iter_mode_e;

  localparam int ALU_WIDTH_DEFAULT = 32;

  // Request-to-result latency of MUL/DIVU/REMU in cycles: WIDTH+1
  // (one capture cycle plus WIDTH iteration steps), shown for the default WIDTH.
  localparam int ALU_LATENCY_ITER = ALU_WIDTH_DEFAULT + 1;

  // True for the codes handled by the multi-cycle iteration unit.
  function automatic logic is_iter_op(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
    return (op == OP_MUL);
`endif
  endfunction

  // Iteration-unit mode for an iterative code.
  function automatic iter_mode_e iter_mode(input logic [3:0] op);
    case (op)
      OP_DIVU: return ITER_DIVU;
      OP_REMU: return ITER_REMU;
      default: return ITER_MUL;
    endcase
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Shared iteration unit: shift-add multiplier and, with SEQ_ALU_DIV_EN defined,
// a restoring divider. Both reuse the same accumulator, operand and counter
// registers. start_i loads the operands; WIDTH steps follow, one per cycle;
// done_o flags the last step and result_o carries that step's outcome.
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  iter_mode_e       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  logic             active_q;
  iter_mode_e       mode_q;
  logic [CNT_W-1:0] cnt_q;
  // MUL: acc = partial product, opa = shifted multiplicand, opb = multiplier.
  // DIV: acc = partial remainder, opa = divisor, opb = dividend/quotient shifter.
  logic [WIDTH-1:0] acc_q, opa_q, opb_q;
  logic [WIDTH-1:0] acc_d, opa_d, opb_d;
`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0]   rem_shift, diff;
`endif

  // One iteration step computed from the current register contents.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    acc_d = acc_q;
    opa_d = opa_q;
    opb_d = opb_q;
`ifdef SEQ_ALU_DIV_EN
    rem_shift = '0;
    diff      = '0;
`endif
    case (mode_q)
`ifdef SEQ_ALU_DIV_EN
      ITER_DIVU, ITER_REMU: begin
        // Bring down the next dividend bit; keep the difference if it did not borrow.
        rem_shift = {acc_q, opb_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, opa_q};
        if (diff[WIDTH]) begin
          acc_d = rem_shift[WIDTH-1:0];
          opb_d = {opb_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = diff[WIDTH-1:0];
          opb_d = {opb_q[WIDTH-2:0], 1'b1};
        end
      end
`endif
      default: begin
        if (opb_q[0]) acc_d = acc_q + opa_q;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
      end
    endcase
  end

  // Result of the step in progress, selected by mode.
  always_comb begin
    case (mode_q)
`ifdef SEQ_ALU_DIV_EN
      ITER_DIVU: result_o = opb_d;
      ITER_REMU: result_o = acc_d;
`endif
      default:   result_o = acc_d;
    endcase
  end

  assign done_o = active_q && (cnt_q == CNT_W'(WIDTH - 1));

  // Operand load on start, then one step per cycle until the last one.
  always_ff @(posedge clk_i) begin
    // NOTE: datapath registers are reset too so an aborted operation leaves no stale state.
    if (rst_i) begin
      active_q <= 1'b0;
      mode_q   <= ITER_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else if (start_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      active_q <= 1'b1;
      mode_q   <= mode_i;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= (mode_i == ITER_MUL) ? a_i : b_i;
      opb_q    <= (mode_i == ITER_MUL) ? b_i : a_i;
    end else if (active_q) begin
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      if (done_o) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on both sides. Single-cycle codes
// load the output register at acceptance; MUL (and DIVU/REMU when
// SEQ_ALU_DIV_EN is defined) run in seq_alu_iter while issue is stalled.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             ovf_o
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_BUSY = BUSY;

  logic [0:0]       state_q;
  logic             accept, iter_op, start, load, iter_done;
  logic [WIDTH-1:0] iter_result;
  logic [WIDTH-1:0] sc_result, load_result, sum, dif;
  logic             sc_ovf, load_ovf;
  logic [SH_W-1:0]  shamt;

  assign ready_o = (state_q == S_IDLE) && (!valid_o || ready_i);
  assign accept  = valid_i && ready_o;
  assign iter_op = is_iter_op(ctrl_i);
  assign start   = accept && iter_op;
  assign shamt   = src2_i[SH_W-1:0];
  assign sum     = src1_i + src2_i;
  assign dif     = src1_i - src2_i;

  // Single-cycle datapath straight from the request operands.
  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    case (ctrl_i)
      OP_AND:  sc_result = src1_i & src2_i;
      OP_OR:   sc_result = src1_i | src2_i;
      OP_ADD: begin
        sc_result = sum;
        sc_ovf    = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
      OP_SLL:  sc_result = src1_i << shamt;
      OP_SRL:  sc_result = src1_i >> shamt;
      OP_SUB: begin
        sc_result = dif;
        sc_ovf    = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (dif[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      OP_SRA:  sc_result = WIDTH'($signed(src1_i) >>> shamt);
      OP_NOR:  sc_result = ~(src1_i | src2_i);
      default: sc_result = '0;
    endcase
  end

  seq_alu_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start),
    .mode_i   (iter_mode(ctrl_i)),
    .a_i      (src1_i),
    .b_i      (src2_i),
    .done_o   (iter_done),
    .result_o (iter_result)
  );

  // Output register loads on a single-cycle accept or on the final iteration step.
  assign load        = (accept && !iter_op) || ((state_q == S_BUSY) && iter_done);
  assign load_result = (state_q == S_BUSY) ? iter_result : sc_result;
  assign load_ovf    = (state_q == S_BUSY) ? 1'b0 : sc_ovf;

  // IDLE/BUSY sequencing of iterative operations.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_q <= S_BUSY;
        S_BUSY:  if (iter_done) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Result register: reload wins over consumption, otherwise hold until taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o  <= 1'b0;
      result_o <= '0;
      zero_o   <= 1'b1;
      ovf_o    <= 1'b0;
    end else if (load) begin
      valid_o  <= 1'b1;
      result_o <= load_result;
      zero_o   <= (load_result == '0);
      ovf_o    <= load_ovf;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule
